// File: rtl/tlul_pkg.sv
// tlul_pkg: TL-UL channel types, host FSM states, opcode helper and word-size constant
package tlul_pkg;

    localparam logic [1:0] TL_WORD_SIZE = 2'd2;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        WAIT,
        DRAIN
    } tl_host_state_e;

    typedef struct packed {
        logic [3:0] instr_type;
        logic [6:0] cmd_intg;
        logic [6:0] data_intg;
    } tl_a_user_t;

    typedef struct packed {
        logic        a_valid;
        tl_a_op_e    a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        tl_a_user_t  a_user;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [7:0]  d_source;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

    function automatic tl_d_op_e exp_d_op(input logic we);
        return we ? AccessAck : AccessAckData;
    endfunction

endpackage

// File: rtl/tlul_cmd_intg_gen.sv
// tlul_cmd_intg_gen: 7-bit folded-parity integrity over the A-channel command and data
module tlul_cmd_intg_gen
    import tlul_pkg::*;
(
    input  logic [3:0]  instr_type,
    input  tl_a_op_e    opcode,
    input  logic [31:0] address,
    input  logic [3:0]  mask,
    input  logic [31:0] data,
    output logic [6:0]  cmd_intg,
    output logic [6:0]  data_intg
);

    function automatic logic [6:0] fold7(input logic [63:0] v);
        logic [6:0] r = '0;
        for (int i = 0; i < 64; i++) r[i % 7] = r[i % 7] ^ v[i];
        return r;
    endfunction

    assign cmd_intg  = fold7({21'd0, instr_type, opcode, mask, address});
    assign data_intg = fold7({32'd0, data});

endmodule

// File: rtl/tlul_host_single.sv
// tlul_host_single: single-outstanding TL-UL host adapter; TLUL_HOST_TIMEOUT_EN adds a response timeout
module tlul_host_single
    import tlul_pkg::*;
#(
    parameter int unsigned SourceId      = 0,
    parameter int unsigned TimeoutCycles = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  be_i,
    input  logic [3:0]  instr_type_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        busy_o,
    output tl_h2d_t     tl_o,
    input  tl_d2h_t     tl_i
);

    localparam logic [7:0] SrcId = 8'(SourceId);

    tl_host_state_e state_q, state_d;
    logic           we_q;
    logic [29:0]    addr_q;
    logic [31:0]    wdata_q;
    logic [3:0]     be_q;
    logic [3:0]     itype_q;
    logic           rvalid_q;
    logic           err_q;
    logic [31:0]    rdata_q;
    logic           rsp_fire;
    logic           rsp_err;
    logic           abort;
    logic [6:0]     cmd_intg;
    logic [6:0]     data_intg;
    tl_a_op_e       a_op;
    logic           unused_addr;

    assign unused_addr = ^addr_i[1:0];

`ifdef TLUL_HOST_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
    logic [CntW-1:0] cnt_q;

    // count silent WAIT cycles, restarting while the request is still on the A channel
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else if (state_q == ADDR) cnt_q <= '0;
        else if (state_q == WAIT && !tl_i.d_valid) cnt_q <= cnt_q + 1'b1;
    end

    assign abort = state_q == WAIT && !tl_i.d_valid && cnt_q == CntW'(TimeoutCycles - 1);
`else
    localparam int unsigned unused_timeout = TimeoutCycles;
    assign abort = 1'b0;
`endif

    assign rsp_fire = state_q == WAIT && tl_i.d_valid;
    assign rsp_err  = tl_i.d_error || tl_i.d_source != SrcId || tl_i.d_opcode != exp_d_op(we_q);
    assign a_op     = !we_q ? Get : (be_q == 4'hF ? PutFullData : PutPartialData);

    // state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else state_q <= state_d;
    end

    // next state and grant; grant is only possible while idle
    always_comb begin
        state_d = state_q;
        gnt_o   = 1'b0;
        case (state_q)
            IDLE: begin
                gnt_o = req_i && !rst_i;
                if (req_i) state_d = ADDR;
            end
            ADDR:  if (tl_i.a_ready) state_d = WAIT;
            WAIT:  if (tl_i.d_valid) state_d = IDLE; else if (abort) state_d = DRAIN;
            DRAIN: if (tl_i.d_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // capture the request on grant so the A channel stays stable until accepted
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            itype_q <= '0;
        end else if (state_q == IDLE && req_i) begin
            we_q    <= we_i;
            addr_q  <= addr_i[31:2];
            wdata_q <= wdata_i;
            be_q    <= be_i;
            itype_q <= instr_type_i;
        end
    end

    // register the response (or timeout abort) and pulse rvalid for one cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rsp_fire || abort;
            if (rsp_fire) begin
                err_q   <= rsp_err;
                rdata_q <= (!we_q && !rsp_err) ? tl_i.d_data : '0;
            end else if (abort) begin
                err_q   <= 1'b1;
                rdata_q <= '0;
            end
        end
    end

    tlul_cmd_intg_gen u_intg (
        .instr_type (itype_q),
        .opcode     (a_op),
        .address    ({addr_q, 2'b00}),
        .mask       (we_q ? be_q : 4'hF),
        .data       (wdata_q),
        .cmd_intg   (cmd_intg),
        .data_intg  (data_intg)
    );

    // drive the A channel from captured fields and d_ready while a response is awaited
    always_comb begin
        tl_o                   = '0;
        tl_o.a_valid           = state_q == ADDR;
        tl_o.a_opcode          = a_op;
        tl_o.a_param           = 3'd0;
        tl_o.a_size            = TL_WORD_SIZE;
        tl_o.a_source          = SrcId;
        tl_o.a_address         = {addr_q, 2'b00};
        tl_o.a_mask            = we_q ? be_q : 4'hF;
        tl_o.a_data            = wdata_q;
        tl_o.a_user.instr_type = itype_q;
        tl_o.a_user.cmd_intg   = cmd_intg;
        tl_o.a_user.data_intg  = data_intg;
        tl_o.d_ready           = state_q == WAIT || state_q == DRAIN;
    end

    assign rvalid_o = rvalid_q;
    assign err_o    = err_q;
    assign rdata_o  = rdata_q;
    assign busy_o   = state_q != IDLE;

endmodule

// File: tb/tb_tlul_host_single.sv
// tb_tlul_host_single: directed-sequence bench with randomized transactions and a transaction-level model
module tb_tlul_host_single;
    import tlul_pkg::*;

    localparam int unsigned SID = 3;
    localparam int unsigned TO  = 8;

    logic        clk_i = 1'b0;
    logic        rst_i, req_i, gnt_o, we_i, rvalid_o, err_o, busy_o;
    logic [31:0] addr_i, wdata_i, rdata_o;
    logic [3:0]  be_i, instr_type_i;
    tl_h2d_t     tl_o;
    tl_d2h_t     tl_i;

    int n_cmp = 0;
    int n_bad = 0;

    logic        t_we, t_derr;
    logic [31:0] t_addr, t_wdata, t_ddata, last_rdata;
    logic [3:0]  t_be, t_it;
    logic [7:0]  t_src;
    logic [2:0]  t_dop;
    int          t_rdy, t_rsp;

    always #5 clk_i = ~clk_i;

    tlul_host_single #(.SourceId(SID), .TimeoutCycles(TO)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_i        (req_i),
        .gnt_o        (gnt_o),
        .we_i         (we_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .be_i         (be_i),
        .instr_type_i (instr_type_i),
        .rvalid_o     (rvalid_o),
        .rdata_o      (rdata_o),
        .err_o        (err_o),
        .busy_o       (busy_o),
        .tl_o         (tl_o),
        .tl_i         (tl_i)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // TL-UL A opcode codes: Get=4, PutFullData=0, PutPartialData=1
    function automatic logic [2:0] m_aop(input logic we, input logic [3:0] be);
        if (!we) return 3'd4;
        if (be == 4'hF) return 3'd0;
        return 3'd1;
    endfunction

    function automatic logic m_err();
        logic [2:0] want = t_we ? 3'd0 : 3'd1;
        return t_derr || t_src != 8'(SID) || t_dop != want;
    endfunction

    task automatic rand_txn();
        t_we    = 1'($urandom_range(0, 1));
        t_addr  = $urandom;
        t_wdata = $urandom;
        t_be    = 4'($urandom_range(0, 15));
        t_it    = 4'($urandom_range(0, 15));
        t_rdy   = int'($urandom_range(0, 3));
        t_rsp   = int'($urandom_range(0, 3));
        t_derr  = $urandom_range(0, 4) == 0;
        t_src   = $urandom_range(0, 4) == 0 ? 8'(SID + 1) : 8'(SID);
        t_dop   = $urandom_range(0, 3) == 0 ? 3'd2 : (t_we ? 3'd0 : 3'd1);
        t_ddata = $urandom;
    endtask

    task automatic issue();
        req_i        = 1'b1;
        we_i         = t_we;
        addr_i       = t_addr;
        wdata_i      = t_wdata;
        be_i         = t_be;
        instr_type_i = t_it;
        #1;
        chk("gnt_idle", gnt_o, 1);
    endtask

    task automatic complete();
        logic        exp_err;
        logic [31:0] exp_rdata;
        exp_err   = m_err();
        exp_rdata = (!t_we && !exp_err) ? t_ddata : 32'h0;
        for (int i = 0; i <= t_rdy; i++) begin
            tick();
            req_i         = 1'b1;
            we_i          = ~t_we;
            addr_i        = ~t_addr;
            wdata_i       = ~t_wdata;
            be_i          = ~t_be;
            instr_type_i  = ~t_it;
            tl_i.a_ready  = i == t_rdy;
            #1;
            chk("a_valid", tl_o.a_valid, 1);
            chk("gnt_busy", gnt_o, 0);
            chk("busy_addr", busy_o, 1);
            chk("d_ready_addr", tl_o.d_ready, 0);
            chk("rvalid_addr", rvalid_o, 0);
            chk("a_opcode", tl_o.a_opcode, m_aop(t_we, t_be));
            chk("a_address", tl_o.a_address, {t_addr[31:2], 2'b00});
            chk("a_mask", tl_o.a_mask, t_we ? t_be : 4'hF);
            chk("a_size", tl_o.a_size, 2);
            chk("a_param", tl_o.a_param, 0);
            chk("a_source", tl_o.a_source, SID);
            chk("a_instr", tl_o.a_user.instr_type, t_it);
            if (t_we) chk("a_data", tl_o.a_data, t_wdata);
        end
        tick();
        req_i        = 1'b0;
        tl_i.a_ready = 1'b0;
        for (int i = 0; i <= t_rsp; i++) begin
            tl_i.d_valid  = i == t_rsp;
            tl_i.d_opcode = t_dop;
            tl_i.d_source = t_src;
            tl_i.d_error  = t_derr;
            tl_i.d_data   = t_ddata;
            #1;
            chk("a_valid_wait", tl_o.a_valid, 0);
            chk("d_ready_wait", tl_o.d_ready, 1);
            chk("rvalid_wait", rvalid_o, 0);
            chk("busy_wait", busy_o, 1);
            tick();
        end
        tl_i.d_valid = 1'b0;
        #1;
        chk("rvalid", rvalid_o, 1);
        chk("err", err_o, exp_err);
        chk("rdata", rdata_o, exp_rdata);
        chk("busy_done", busy_o, 0);
        last_rdata = exp_rdata;
    endtask

    initial begin
        rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
        be_i = '0; instr_type_i = '0; tl_i = '0;
        tick();
        chk("rst_a_valid", tl_o.a_valid, 0);
        chk("rst_d_ready", tl_o.d_ready, 0);
        chk("rst_rvalid", rvalid_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_busy", busy_o, 0);
        tick();
        rst_i = 1'b0;
        tick();

        // minimum-latency read returning 0xDEADBEEF
        t_we = 1'b0; t_addr = 32'h1000; t_wdata = '0; t_be = 4'hF; t_it = 4'h9;
        t_rdy = 0; t_rsp = 0; t_derr = 1'b0; t_src = 8'(SID); t_dop = 3'd1; t_ddata = 32'hDEADBEEF;
        issue();
        complete();

        // partial write at an unaligned address
        tick();
        t_we = 1'b1; t_addr = 32'h1003; t_wdata = $urandom; t_be = 4'b0011; t_it = 4'h6;
        t_rdy = 0; t_rsp = 1; t_derr = 1'b0; t_src = 8'(SID); t_dop = 3'd0; t_ddata = $urandom;
        issue();
        complete();

        // a_ready held off for five cycles
        tick();
        rand_txn(); t_rdy = 5;
        issue();
        complete();

        // device error, then wrong source, each must flag err with zero data
        tick();
        rand_txn(); t_we = 1'b0; t_derr = 1'b1; t_src = 8'(SID); t_dop = 3'd1;
        issue();
        complete();
        tick();
        rand_txn(); t_we = 1'b0; t_derr = 1'b0; t_src = 8'(SID + 1); t_dop = 3'd1;
        issue();
        complete();

        // new request granted in the same cycle as rvalid
        rand_txn();
        issue();
        complete();

        // read data held after the strobe
        tick();
        chk("rvalid_pulse", rvalid_o, 0);
        chk("rdata_hold", rdata_o, last_rdata);

        repeat (25) begin
            rand_txn();
            if ($urandom_range(0, 1) == 1) tick();
            issue();
            complete();
        end

        // response never arrives within the timeout window
        rand_txn(); t_we = 1'b0; t_rdy = 0; t_derr = 1'b0; t_src = 8'(SID); t_dop = 3'd1;
`ifdef TLUL_HOST_TIMEOUT_EN
        tick();
        issue();
        tick();
        req_i = 1'b0;
        tl_i.a_ready = 1'b1;
        #1;
        chk("to_a_valid", tl_o.a_valid, 1);
        tick();
        tl_i.a_ready = 1'b0;
        for (int k = 1; k <= TO; k++) begin
            #1;
            chk("to_rvalid_wait", rvalid_o, 0);
            chk("to_busy_wait", busy_o, 1);
            tick();
        end
        #1;
        chk("to_rvalid", rvalid_o, 1);
        chk("to_err", err_o, 1);
        chk("to_rdata", rdata_o, 0);
        chk("to_d_ready", tl_o.d_ready, 1);
        tick();
        chk("drain_rvalid", rvalid_o, 0);
        chk("drain_busy", busy_o, 1);
        tl_i.d_valid = 1'b1; tl_i.d_source = 8'(SID); tl_i.d_opcode = 3'd1; tl_i.d_error = 1'b0;
        tick();
        tl_i.d_valid = 1'b0;
        chk("drain_exit_busy", busy_o, 0);
        issue();
        chk("drain_no_rvalid", rvalid_o, 0);
        complete();
`else
        t_rsp = 80;
        tick();
        issue();
        complete();
`endif

        // reset while waiting for the response
        tick();
        rand_txn();
        issue();
        tick();
        req_i = 1'b0;
        tl_i.a_ready = 1'b1;
        #1;
        chk("rstw_a_valid_pre", tl_o.a_valid, 1);
        tick();
        tl_i.a_ready = 1'b0;
        #1;
        chk("rstw_d_ready_pre", tl_o.d_ready, 1);
        rst_i = 1'b1;
        #1;
        chk("rstw_a_valid", tl_o.a_valid, 0);
        chk("rstw_d_ready", tl_o.d_ready, 0);
        chk("rstw_busy", busy_o, 0);
        chk("rstw_rvalid", rvalid_o, 0);
        tick();
        rst_i = 1'b0;
        tl_i.d_valid = 1'b1; tl_i.d_source = 8'(SID); tl_i.d_opcode = 3'd1; tl_i.d_error = 1'b0;
        tick();
        tl_i.d_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("rstw_no_rvalid", rvalid_o, 0);
            tick();
        end

        // reset while the request is still on the A channel
        rand_txn();
        issue();
        tick();
        req_i = 1'b0;
        tl_i.a_ready = 1'b0;
        #1;
        chk("rsta_a_valid_pre", tl_o.a_valid, 1);
        rst_i = 1'b1;
        #1;
        chk("rsta_a_valid", tl_o.a_valid, 0);
        chk("rsta_busy", busy_o, 0);
        tick();
        rst_i = 1'b0;
        tl_i.a_ready = 1'b1;
        #1;
        chk("rsta_idle_a_valid", tl_o.a_valid, 0);
        tick();
        tl_i.a_ready = 1'b0;
        chk("rsta_no_rvalid", rvalid_o, 0);

        // normal service resumes after reset
        rand_txn();
        issue();
        complete();

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
